// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : valid/ready data-memory responder, programmable wait states,
//                  word RAM at BASE_ADDR; byte strobes enabled by DMEM_WSTRB_EN.
// Rev 1.0
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_WSTRB_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam bit          NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [3:0]  wstrb_in;
  logic        txn_we;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic [3:0]  txn_wstrb;
  logic [31:0] txn_offset;
  logic        txn_err;
  logic [AW-1:0] txn_idx;
  logic        enter_resp;
  logic        mem_we;

`ifdef DMEM_WSTRB_EN
  assign wstrb_in = req_wstrb;
`else
  assign wstrb_in = 4'hF;
`endif

  // With zero wait states RESP is entered on the accept edge, so the live request is used.
  always_comb begin
    txn_we    = we_q;
    txn_addr  = addr_q;
    txn_wdata = wdata_q;
    txn_wstrb = wstrb_q;
    if (state_q == S_IDLE) begin
      txn_we    = req_we;
      txn_addr  = req_addr;
      txn_wdata = req_wdata;
      txn_wstrb = wstrb_in;
    end
  end

  assign txn_offset = txn_addr - BASE_ADDR;
  assign txn_idx    = txn_offset[AW+1:2];
  assign txn_err    = (txn_addr[1:0] != 2'b00) || (txn_addr < BASE_ADDR)
                   || ({1'b0, txn_offset} >= SPAN);

  assign enter_resp = ((state_q == S_IDLE) && req_valid && NO_WAIT)
                   || ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign mem_we     = enter_resp && txn_we && !txn_err && !reset;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = wstrb_in;
          cnt_d   = CNT_INIT;
          state_d = NO_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response payload is captured only on the edge entering RESP and cleared otherwise.
  always_comb begin
    rdata_d = 32'd0;
    err_d   = 1'b0;
    if (enter_resp) begin
      err_d = txn_err;
      if (!txn_we && !txn_err) rdata_d = mem[txn_idx];
    end
  end

  // Output logic
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (txn_wstrb[i]) mem[txn_idx][8*i +: 8] <= txn_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
